switch_debounce_filter: RTL and testbench

//   Front-end conditioning stage for a raw mechanical push-button/slide switch.

---
 rtl/switch_debounce_filter_pkg.sv | 16 +
 rtl/switch_debounce_filter_if.sv | 41 ++++
 rtl/switch_debounce_filter_sync_2ff.sv | 29 ++
 rtl/switch_debounce_filter.sv | 106 ++++++++++
 tb/tb_switch_debounce_filter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_debounce_filter_pkg.sv
// Shared constants for the switch debounce front-end: FSM encodings and limits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

    // Debounce FSM state encodings (1-bit, legacy-compatible constants)
    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_QUALIFY = 1'b1;

    // 10 ms at 25 MHz
    localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;

    // Short limit so simulations reach a decision in a handful of cycles
    localparam int SIM_DEBOUNCE_LIMIT = 4;

endpackage

// File: rtl/switch_debounce_filter_if.sv
// Pin-side bundle of the debounce filter: raw switch in, clean level/status out.
// Latency: n/a (wires only).
// Backpressure: none; all signals are free-running levels or single-cycle pulses.
//   i_Switch  raw asynchronous switch pin
//   o_Switch  debounced, synchronised level
//   o_Busy    high while a level change is being qualified
//   o_Rise    one-cycle pulse on debounced 0->1 (only with DEBOUNCE_EDGE_PULSE_EN)
//   o_Fall    one-cycle pulse on debounced 1->0 (only with DEBOUNCE_EDGE_PULSE_EN)
interface switch_debounce_filter_if;

    logic i_Switch;
    logic o_Switch;
    logic o_Busy;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic o_Rise;
    logic o_Fall;
`endif

    // Filter side
    modport slave (
        input  i_Switch,
        output o_Switch,
`ifdef DEBOUNCE_EDGE_PULSE_EN
        output o_Rise,
        output o_Fall,
`endif
        output o_Busy
    );

    // Pin driver / consumer side
    modport master (
        output i_Switch,
        input  o_Switch,
`ifdef DEBOUNCE_EDGE_PULSE_EN
        input  o_Rise,
        input  o_Fall,
`endif
        input  o_Busy
    );

endinterface

// File: rtl/switch_debounce_filter_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous pin into the clk domain.
// Latency: 2 clk cycles from pin change to q.
// Backpressure: none; free-running.
//   clk    destination clock
//   rst_n  asynchronous active-low reset; both flops load RESET_LEVEL
//   d      asynchronous input
//   q      synchronised output (second flop)
module sync_2ff #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_LEVEL;
            q    <= RESET_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/switch_debounce_filter.sv
// Debounce filter: synchronises a bouncy switch pin and only follows a level held stable.
// Latency: o_Switch follows a held pin change DEBOUNCE_LIMIT+1 edges after it is first sampled.
// Backpressure: none; changes shorter than DEBOUNCE_LIMIT cycles are silently dropped.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN adds registered o_Rise/o_Fall pulses.
//   i_Clk    system clock
//   i_Rst_L  asynchronous active-low reset
//   sw       pin bundle (i_Switch in; o_Switch, o_Busy, [o_Rise, o_Fall] out)
module switch_debounce_filter
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    switch_debounce_filter_if.slave   sw
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_sw;
    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic             level_q;
    logic             take;

    sync_2ff #(
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .d     (sw.i_Switch),
        .q     (sync_sw)
    );

    // Accept the new level this edge: either the qualification window just
    // completed, or the limit is 1 and a single mismatching sample suffices.
    always_comb begin
        take = 1'b0;
        if (sync_sw != level_q) begin
            if (state == ST_QUALIFY) begin
                take = (count == CNT_LAST);
            end else begin
                take = (DEBOUNCE_LIMIT == 1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= ST_STABLE;
            count   <= '0;
            level_q <= RESET_LEVEL;
        end else if (take) begin
            level_q <= sync_sw;
            count   <= '0;
            state   <= ST_STABLE;
        end else begin
            case (state)
                ST_STABLE: begin
                    count <= '0;
                    if (sync_sw != level_q) begin
                        state <= ST_QUALIFY;
                        count <= CNT_ONE;
                    end
                end
                default: begin
                    if (sync_sw == level_q) begin
                        // Pin returned to the old level: glitch rejected
                        state <= ST_STABLE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            endcase
        end
    end

    assign sw.o_Switch = level_q;
    assign sw.o_Busy   = (state == ST_QUALIFY);

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q;
    logic fall_q;

    // Pulses fire on the same edge level_q updates, so they align with o_Switch
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= take &&  sync_sw;
            fall_q <= take && !sync_sw;
        end
    end

    assign sw.o_Rise = rise_q;
    assign sw.o_Fall = fall_q;
`else
    // Level-only build: no edge pulse outputs.
`endif

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Directed bench for switch_debounce_filter with DEBOUNCE_LIMIT=4, RESET_LEVEL=0.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point,
// so "edge k" below is the k-th rising edge after the pin change was driven.
module tb_switch_debounce_filter;
    import debounce_pkg::*;

    localparam int LIMIT = SIM_DEBOUNCE_LIMIT;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    switch_debounce_filter_if sw();

    switch_debounce_filter #(
        .DEBOUNCE_LIMIT (LIMIT),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .sw      (sw)
    );

    always #5 clk = ~clk;

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        sw.i_Switch = 1'b0;
        clk_edge();
        clk_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        sw.i_Switch = 1'b1;
        repeat (3) clk_edge();
        tests_run++;
        if (sw.o_Switch !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_o_switch: got %b expected 0", sw.o_Switch);
        end
        tests_run++;
        if (sw.o_Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_o_busy: got %b expected 0", sw.o_Busy);
        end
`ifdef DEBOUNCE_EDGE_PULSE_EN
        tests_run++;
        if ({sw.o_Rise, sw.o_Fall} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_pulses: got rise/fall %b%b expected 00", sw.o_Rise, sw.o_Fall);
        end
`endif
        // Pin already high at release: full qualification, no shortcut
        rst_n = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            clk_edge();
            tests_run++;
            if (sw.o_Switch !== (k >= 5)) begin
                tests_failed++;
                $display("FAIL reset_release_o_switch edge %0d: got %b expected %b", k, sw.o_Switch, (k >= 5));
            end
`ifdef DEBOUNCE_EDGE_PULSE_EN
            tests_run++;
            if (sw.o_Rise !== (k == 5)) begin
                tests_failed++;
                $display("FAIL reset_release_o_rise edge %0d: got %b expected %b", k, sw.o_Rise, (k == 5));
            end
`endif
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        sw.i_Switch = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            clk_edge();
            tests_run++;
            if (sw.o_Switch !== (k >= 5)) begin
                tests_failed++;
                $display("FAIL press_o_switch edge %0d: got %b expected %b", k, sw.o_Switch, (k >= 5));
            end
            tests_run++;
            if (sw.o_Busy !== (k >= 2 && k <= 4)) begin
                tests_failed++;
                $display("FAIL press_o_busy edge %0d: got %b expected %b", k, sw.o_Busy, (k >= 2 && k <= 4));
            end
`ifdef DEBOUNCE_EDGE_PULSE_EN
            tests_run++;
            if ({sw.o_Rise, sw.o_Fall} !== {(k == 5), 1'b0}) begin
                tests_failed++;
                $display("FAIL press_pulses edge %0d: got rise/fall %b%b expected %b0", k, sw.o_Rise, sw.o_Fall, (k == 5));
            end
`endif
        end
    endtask

    task automatic test_bounce();
        int rises;
        rises = 0;
        do_reset();
        // Two cycles high, two low, for 20 cycles: never stable for 4
        for (int c = 0; c < 20; c++) begin
            sw.i_Switch = (((c / 2) % 2) == 0);
            clk_edge();
            tests_run++;
            if (sw.o_Switch !== 1'b0) begin
                tests_failed++;
                $display("FAIL bounce_o_switch cycle %0d: got %b expected 0", c, sw.o_Switch);
            end
`ifdef DEBOUNCE_EDGE_PULSE_EN
            if (sw.o_Rise === 1'b1) rises++;
`endif
        end
        sw.i_Switch = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            clk_edge();
            tests_run++;
            if (sw.o_Switch !== (k >= 5)) begin
                tests_failed++;
                $display("FAIL bounce_settle_o_switch edge %0d: got %b expected %b", k, sw.o_Switch, (k >= 5));
            end
`ifdef DEBOUNCE_EDGE_PULSE_EN
            if (sw.o_Rise === 1'b1) rises++;
`endif
        end
`ifdef DEBOUNCE_EDGE_PULSE_EN
        tests_run++;
        if (rises != 1) begin
            tests_failed++;
            $display("FAIL bounce_rise_count: got %0d expected 1", rises);
        end
`endif
    endtask

    task automatic test_glitch();
        do_reset();
        // High for 3 cycles (one short of the limit)
        sw.i_Switch = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            if (k == 3) sw.i_Switch = 1'b0;
            clk_edge();
            tests_run++;
            if (sw.o_Switch !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_o_switch edge %0d: got %b expected 0", k, sw.o_Switch);
            end
            tests_run++;
            if (sw.o_Busy !== (k >= 2 && k <= 4)) begin
                tests_failed++;
                $display("FAIL glitch_o_busy edge %0d: got %b expected %b", k, sw.o_Busy, (k >= 2 && k <= 4));
            end
`ifdef DEBOUNCE_EDGE_PULSE_EN
            tests_run++;
            if ({sw.o_Rise, sw.o_Fall} !== 2'b00) begin
                tests_failed++;
                $display("FAIL glitch_pulses edge %0d: got rise/fall %b%b expected 00", k, sw.o_Rise, sw.o_Fall);
            end
`endif
        end
    endtask

    task automatic test_exact_limit_pulse();
        do_reset();
        // High for exactly 4 cycles: accepted, then the return to 0 is accepted too
        sw.i_Switch = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            if (k == 4) sw.i_Switch = 1'b0;
            clk_edge();
            tests_run++;
            if (sw.o_Switch !== (k >= 5 && k <= 8)) begin
                tests_failed++;
                $display("FAIL exact_o_switch edge %0d: got %b expected %b", k, sw.o_Switch, (k >= 5 && k <= 8));
            end
            tests_run++;
            if (sw.o_Busy !== ((k >= 2 && k <= 4) || (k >= 6 && k <= 8))) begin
                tests_failed++;
                $display("FAIL exact_o_busy edge %0d: got %b expected %b", k, sw.o_Busy,
                         ((k >= 2 && k <= 4) || (k >= 6 && k <= 8)));
            end
`ifdef DEBOUNCE_EDGE_PULSE_EN
            tests_run++;
            if ({sw.o_Rise, sw.o_Fall} !== {(k == 5), (k == 9)}) begin
                tests_failed++;
                $display("FAIL exact_pulses edge %0d: got rise/fall %b%b expected %b%b", k, sw.o_Rise, sw.o_Fall, (k == 5), (k == 9));
            end
`endif
        end
    endtask

    task automatic test_release();
        do_reset();
        sw.i_Switch = 1'b1;
        repeat (7) clk_edge();
        tests_run++;
        if (sw.o_Switch !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_setup_o_switch: got %b expected 1", sw.o_Switch);
        end
        sw.i_Switch = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            clk_edge();
            tests_run++;
            if (sw.o_Switch !== (k < 5)) begin
                tests_failed++;
                $display("FAIL release_o_switch edge %0d: got %b expected %b", k, sw.o_Switch, (k < 5));
            end
            tests_run++;
            if (sw.o_Busy !== (k >= 2 && k <= 4)) begin
                tests_failed++;
                $display("FAIL release_o_busy edge %0d: got %b expected %b", k, sw.o_Busy, (k >= 2 && k <= 4));
            end
`ifdef DEBOUNCE_EDGE_PULSE_EN
            tests_run++;
            if ({sw.o_Rise, sw.o_Fall} !== {1'b0, (k == 5)}) begin
                tests_failed++;
                $display("FAIL release_pulses edge %0d: got rise/fall %b%b expected 0%b", k, sw.o_Rise, sw.o_Fall, (k == 5));
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        sw.i_Switch = 1'b1;
        repeat (4) clk_edge();   // edges 0..3: qualifying with count 2
        tests_run++;
        if (sw.o_Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_pre_busy: got %b expected 1", sw.o_Busy);
        end
        // Asynchronous assertion between edges
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (sw.o_Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_o_busy: got %b expected 0", sw.o_Busy);
        end
        tests_run++;
        if (sw.o_Switch !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_o_switch: got %b expected 0", sw.o_Switch);
        end
        clk_edge();
        rst_n = 1'b1;
        // Qualification restarts from scratch after release
        for (int k = 0; k <= 5; k++) begin
            clk_edge();
            tests_run++;
            if (sw.o_Switch !== (k >= 5)) begin
                tests_failed++;
                $display("FAIL midreset_requalify_o_switch edge %0d: got %b expected %b", k, sw.o_Switch, (k >= 5));
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        sw.i_Switch = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_exact_limit_pulse();
        test_release();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
